// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register built as a 2-entry skid buffer with valid/ready on both sides.
// Define IF_ID_SKID_PERF_CNT_EN to add the stall_cycles / flush_drops counters.
module if_id_skid_register #(
  parameter int                XLEN      = 32,
  parameter int                ILEN      = 32,
  parameter logic [ILEN-1:0]   NOP_INSTR = 32'h00000013,
  parameter logic [XLEN-1:0]   BUBBLE_PC = '0,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
`ifdef IF_ID_SKID_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_drops,
`endif
  output logic [1:0]       occupancy
);

  // Encoding is {skid_valid, main_valid}, so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ILEN-1:0]   main_instr_q, main_instr_d;
  logic [XLEN-1:0]   main_pc_q, main_pc_d;
  logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;

  logic main_valid, skid_valid, accept, consume;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // in_ready comes only from registers so decode backpressure never ripples into fetch.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid & out_ready;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign out_instr = main_valid ? main_instr_q : NOP_INSTR;
  assign out_pc    = main_valid ? main_pc_q    : BUBBLE_PC;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = BUSY;
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end
      end
      BUSY: begin
        if (accept && consume) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end else if (accept) begin
          state_d      = FULL;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d      = BUSY;
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) state_d = EMPTY;
  end

  // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: payload carries no reset; it is masked by the valid bits and never visible while stale.
  always_ff @(posedge clk) begin
    main_instr_q <= main_instr_d;
    main_pc_q    <= main_pc_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

`ifdef IF_ID_SKID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, drops_q;
  logic             stall_inc, drop_inc;

  assign stall_inc = main_valid & ~out_ready & ~(&stall_q);
  assign drop_inc  = flush & ((occupancy != 2'd0) | accept) & ~(&drops_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      if (stall_inc) stall_q <= stall_q + 1'b1;
      if (drop_inc)  drops_q <= drops_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_drops  = drops_q;
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Self-checking bench for if_id_skid_register: directed scenarios plus random traffic
// compared against a 2-deep FIFO reference model.
module tb_if_id_skid_register;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [1:0]  occupancy;
`ifdef IF_ID_SKID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_drops;
`endif

  if_id_skid_register #(
    .XLEN(32), .ILEN(32), .NOP_INSTR(32'h00000013), .BUBBLE_PC(32'h0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
`ifdef IF_ID_SKID_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_drops(flush_drops),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t model_q[$];
  int    m_stall, m_drops;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_stall = 0;
    m_drops = 0;
  endtask

  // Compare all outputs against the model, then advance the model by one clock edge.
  task automatic cycle();
    bit acc, cons, had;
    @(negedge clk);
    had = model_q.size() > 0;
    check("out_valid", out_valid, had);
    check("in_ready",  in_ready,  model_q.size() < 2);
    check("occupancy", occupancy, model_q.size());
    check("out_instr", out_instr, had ? model_q[0].instr : 32'h00000013);
    check("out_pc",    out_pc,    had ? model_q[0].pc    : 32'h0);
`ifdef IF_ID_SKID_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_drops",  flush_drops,  m_drops);
`endif
    acc  = in_valid && (model_q.size() < 2);
    cons = had && out_ready;
    if (had && !out_ready && m_stall < CMAX) m_stall++;
    if (flush) begin
      if ((had || acc) && m_drops < CMAX) m_drops++;
      model_q.delete();
    end else begin
      if (cons) void'(model_q.pop_front());
      if (acc)  model_q.push_back('{pc: in_pc, instr: in_instr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic drain();
    drive(0, 32'h0, 32'h0, 1, 0);
    repeat (3) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr_tbl [3];
    bit          rdy;
    int          tries;
    instr_tbl[0] = 32'hAAAAAAAA;
    instr_tbl[1] = 32'hBBBBBBBB;
    instr_tbl[2] = 32'hCCCCCCCC;

    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    model_reset();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 32'h00000013);
    check("rst_occupancy", occupancy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Counter saturation: one beat stalled for 20 cycles, then flushed.
    drive(1, 32'h4, 32'hAAAAAAAA, 0, 0);
    cycle();
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (20) cycle();
    drive(0, 32'h0, 32'h0, 0, 1);
    cycle();
`ifdef IF_ID_SKID_PERF_CNT_EN
    check("perf_stall_sat", stall_cycles, 15);
    check("perf_drops",     flush_drops,  1);
`endif
    drain();

    // Streaming at full rate.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4 * (i + 1)), instr_tbl[i], 1, 0);
      cycle();
      check("stream_pc",    out_pc,    32'(4 * (i + 1)));
      check("stream_instr", out_instr, instr_tbl[i]);
    end
    drain();

    // Backpressure fills both entries, third beat waits for in_ready.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'(4 * (i + 1)), instr_tbl[i], 0, 0);
      cycle();
    end
    check("bp_occupancy", occupancy, 2);
    check("bp_in_ready",  in_ready,  0);
    tries = 0;
    drive(1, 32'hC, instr_tbl[2], 0, 0);
    do begin
      rdy = in_ready;
      out_ready = (tries >= 2);
      cycle();
      tries++;
    end while (!rdy && tries < 10);
    check("bp_accept_bound", tries < 10, 1);
    drain();

    // Flush beats an accept and a held FULL state.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'(4 * (i + 1)), instr_tbl[i], 0, 0);
      cycle();
    end
    drive(1, 32'hC, instr_tbl[2], 0, 1);
    cycle();
    drive(0, 32'h0, 32'h0, 1, 0);
    check("flush_valid", out_valid, 0);
    check("flush_instr", out_instr, 32'h00000013);
    check("flush_pc",    out_pc,    32'h0);
    check("flush_occ",   occupancy, 0);
    drain();

    // Accept and consume together in BUSY.
    drive(1, 32'h4, instr_tbl[0], 0, 0);
    cycle();
    drive(1, 32'h8, instr_tbl[1], 1, 0);
    cycle();
    check("busy_swap_pc",  out_pc,    32'h8);
    check("busy_swap_occ", occupancy, 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      cycle();
    end

    // Asynchronous reset while FULL.
    drain();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'(4 * (i + 1)), instr_tbl[i], 0, 0);
      cycle();
    end
    drive(0, 32'h0, 32'h0, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst_valid", out_valid, 0);
    check("arst_instr", out_instr, 32'h00000013);
    check("arst_pc",    out_pc,    32'h0);
    check("arst_occ",   occupancy, 0);
`ifdef IF_ID_SKID_PERF_CNT_EN
    check("arst_stall", stall_cycles, 0);
    check("arst_drops", flush_drops,  0);
`endif
    @(negedge clk) reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    drive(1, 32'h10, 32'hDDDDDDDD, 1, 0);
    cycle();
    check("post_rst_pc", out_pc, 32'h10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
